// File: rtl/cpu_trace_buffer.sv
// Post-mortem trace recorder: stores one {pc, instr} entry per distinct fetched PC
// in a circular buffer, stops a fixed number of entries after a PC trigger, then drains oldest-first.
module cpu_trace_buffer #(
    parameter int ADDR_W   = 4,
    parameter int POST_CNT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc,
    input  logic [31:0]       instr,
    input  logic              arm,
    input  logic              trig_ena,
    input  logic [31:0]       trig_pc,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [31:0]       rd_pc,
    output logic [31:0]       rd_instr,
    output logic [ADDR_W:0]   count,
    output logic [1:0]        state,
    output logic              overflow
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_CAPTURE = 2'b01,
        S_POST    = 2'b10,
        S_DONE    = 2'b11
    } state_t;

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL      = DEPTH[ADDR_W:0];
    localparam logic [7:0]      POST_INIT = POST_CNT[7:0];

    state_t              r_state, w_state_nxt;
    logic [63:0]         r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_overflow;
    logic [31:0]         r_last_pc;
    logic                r_last_valid;
    logic [7:0]          r_post_cnt;

    logic w_sample, w_trig, w_full, w_rd_valid, w_rd_fire;

    // A stalled CPU holds pc; only a new PC (or the first after arm) is a sample.
    assign w_sample   = (r_state == S_CAPTURE || r_state == S_POST) &&
                        (!r_last_valid || pc != r_last_pc);
    assign w_trig     = w_sample && r_state == S_CAPTURE && trig_ena && pc == trig_pc;
    assign w_full     = r_count == FULL;
    assign w_rd_valid = (r_state == S_IDLE || r_state == S_DONE) && r_count != '0;
    assign w_rd_fire  = w_rd_valid && rd_ready;

    always_comb begin
        w_state_nxt = r_state;
        if (arm) begin
            w_state_nxt = S_CAPTURE;
        end else begin
            case (r_state)
                S_CAPTURE: if (w_trig) w_state_nxt = (POST_INIT == 8'd0) ? S_DONE : S_POST;
                S_POST:    if (w_sample && r_post_cnt <= 8'd1) w_state_nxt = S_DONE;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst || arm) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_last_valid <= 1'b0;
            r_last_pc    <= '0;
            r_post_cnt   <= '0;
        end else begin
            if (w_sample) begin
                r_wr_ptr     <= r_wr_ptr + 1'b1;
                r_last_pc    <= pc;
                r_last_valid <= 1'b1;
                if (w_full) begin
                    r_rd_ptr   <= r_rd_ptr + 1'b1;
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count  <= r_count - 1'b1;
            end
            if (w_trig)
                r_post_cnt <= POST_INIT;
            else if (r_state == S_POST && w_sample)
                r_post_cnt <= r_post_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !arm && w_sample)
            r_mem[r_wr_ptr] <= {pc, instr};
    end

    assign rd_valid = w_rd_valid;
    assign rd_pc    = w_rd_valid ? r_mem[r_rd_ptr][63:32] : '0;
    assign rd_instr = w_rd_valid ? r_mem[r_rd_ptr][31:0]  : '0;
    assign count    = r_count;
    assign state    = r_state;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: two instances (POST_CNT=2 and POST_CNT=0) share stimulus,
// each scenario checks the instance it targets.
module tb_cpu_trace_buffer;

    logic        clk = 1'b0;
    logic        rst, arm, trig_ena, rd_ready;
    logic [31:0] pc, instr, trig_pc;

    logic        a_valid, b_valid, a_ovf, b_ovf;
    logic [31:0] a_pc, a_instr, b_pc, b_instr;
    logic [4:0]  a_cnt, b_cnt;
    logic [1:0]  a_st, b_st;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_trace_buffer #(.ADDR_W(4), .POST_CNT(2)) u_a (
        .clk(clk), .rst(rst), .pc(pc), .instr(instr), .arm(arm), .trig_ena(trig_ena),
        .trig_pc(trig_pc), .rd_ready(rd_ready), .rd_valid(a_valid), .rd_pc(a_pc),
        .rd_instr(a_instr), .count(a_cnt), .state(a_st), .overflow(a_ovf)
    );

    cpu_trace_buffer #(.ADDR_W(4), .POST_CNT(0)) u_b (
        .clk(clk), .rst(rst), .pc(pc), .instr(instr), .arm(arm), .trig_ena(trig_ena),
        .trig_pc(trig_pc), .rd_ready(rd_ready), .rd_valid(b_valid), .rd_pc(b_pc),
        .rd_instr(b_instr), .count(b_cnt), .state(b_st), .overflow(b_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_instr(input logic [31:0] p);
        return p ^ 32'hA5A5_0000;
    endfunction

    task automatic feed(input logic [31:0] p);
        pc    = p;
        instr = mk_instr(p);
        tick();
    endtask

    task automatic do_arm();
        rd_ready = 1'b0;
        arm      = 1'b1;
        tick();
        arm      = 1'b0;
    endtask

    logic [31:0] exp_a [5];
    logic [31:0] p;

    initial begin
        rst = 1'b1; arm = 1'b0; trig_ena = 1'b1; rd_ready = 1'b0;
        pc = '0; instr = '0; trig_pc = '0;

        // reset
        tick(); tick();
        rst = 1'b0;
        chk("rst_state", a_st, 2'b00);
        chk("rst_count", a_cnt, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_pc", a_pc, 0);
        chk("rst_instr", a_instr, 0);
        chk("rst_b_state", b_st, 2'b00);

        // stall filtering + trigger
        trig_pc = 32'h0040_0008;
        do_arm();
        chk("arm_state", a_st, 2'b01);
        feed(32'h0040_0000); feed(32'h0040_0004); feed(32'h0040_0004);
        feed(32'h0040_0008);
        chk("trig_post", a_st, 2'b10);
        feed(32'h0040_000C); feed(32'h0040_0010); feed(32'h0040_0014);
        chk("stall_done", a_st, 2'b11);
        chk("stall_count", a_cnt, 5);
        exp_a = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008, 32'h0040_000C, 32'h0040_0010};
        rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_rvalid", a_valid, 1);
            chk("stall_rpc", a_pc, exp_a[i]);
            chk("stall_rinstr", a_instr, mk_instr(exp_a[i]));
            tick();
        end
        chk("stall_empty", a_valid, 0);

        // overflow on the POST_CNT=0 instance
        trig_pc = 32'h0000_014C;
        do_arm();
        for (int i = 0; i < 20; i++) feed(32'h100 + 32'(4 * i));
        chk("ovf_state", b_st, 2'b11);
        chk("ovf_count", b_cnt, 16);
        chk("ovf_flag", b_ovf, 1);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            p = 32'h110 + 32'(4 * i);
            chk("ovf_rpc", b_pc, p);
            chk("ovf_rinstr", b_instr, mk_instr(p));
            tick();
        end
        chk("ovf_empty", b_valid, 0);

        // backpressure
        trig_pc = 32'h0000_0200;
        do_arm();
        feed(32'h200); feed(32'h204); feed(32'h208);
        chk("bp_done", a_st, 2'b11);
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_valid", a_valid, 1);
            chk("bp_hold_pc", a_pc, 32'h200);
            chk("bp_hold_instr", a_instr, mk_instr(32'h200));
            chk("bp_hold_count", a_cnt, 3);
            tick();
        end
        rd_ready = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            tick();
            chk("bp_drain_count", a_cnt, 5'(i));
        end
        chk("bp_drain_empty", a_valid, 0);

        // reset mid-POST
        trig_pc = 32'h0000_0308;
        do_arm();
        feed(32'h300); feed(32'h304); feed(32'h308); feed(32'h30C);
        chk("mid_post_state", a_st, 2'b10);
        chk("mid_post_count", a_cnt, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_state", a_st, 2'b00);
        chk("mid_rst_count", a_cnt, 0);
        chk("mid_rst_valid", a_valid, 0);
        feed(32'h310); feed(32'h314);
        chk("idle_norec_count", a_cnt, 0);
        chk("idle_norec_state", a_st, 2'b00);

        // immediate trigger on the POST_CNT=0 instance
        trig_pc = 32'hBFC0_0000;
        pc = 32'hBFC0_0000; instr = mk_instr(32'hBFC0_0000);
        do_arm();
        tick();
        chk("imm_state", b_st, 2'b11);
        chk("imm_count", b_cnt, 1);
        chk("imm_valid", b_valid, 1);
        chk("imm_rpc", b_pc, 32'hBFC0_0000);
        rd_ready = 1'b1;
        arm = 1'b1;
        pc = 32'hBFC0_0004;
        tick();
        arm = 1'b0;
        rd_ready = 1'b0;
        chk("rearm_count", b_cnt, 0);
        chk("rearm_state", b_st, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
